// File: rtl/seq_mul_adder_ctrl.sv
// Sequential shift-add WIDTH x WIDTH unsigned multiplier controller that time-shares
// one external WIDTH-bit adder (exact or approximate) over WIDTH iterations.
module seq_mul_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy,
    output logic [CNT_W-1:0]     done_count,
    output logic [WIDTH-1:0]     adder_a,
    output logic [WIDTH-1:0]     adder_b,
    output logic                 adder_cin,
    input  logic [WIDTH-1:0]     adder_sum,
    input  logic                 adder_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   done_count_q, done_count_d;

    // Adder is driven from registers only; lo[0] selects whether the multiplicand is added.
    assign adder_a   = hi_q;
    assign adder_b   = lo_q[0] ? mcand_q : {WIDTH{1'b0}};
    assign adder_cin = 1'b0;

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_BUSY);
    assign out_valid  = (state_q == ST_DONE);
    assign out_p      = {hi_q, lo_q};
    assign done_count = done_count_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mcand_q      <= {WIDTH{1'b0}};
            hi_q         <= {WIDTH{1'b0}};
            lo_q         <= {WIDTH{1'b0}};
            cnt_q        <= {CW{1'b0}};
            done_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            mcand_q      <= mcand_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            cnt_q        <= cnt_d;
            done_count_q <= done_count_d;
        end
    end

    // Next-state logic; adder results are only consumed in BUSY so X elsewhere is harmless.
    always_comb begin
        state_d      = state_q;
        mcand_d      = mcand_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        cnt_d        = cnt_q;
        done_count_d = done_count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mcand_d = in_a;
                    hi_d    = {WIDTH{1'b0}};
                    lo_d    = in_b;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                hi_d  = {adder_cout, adder_sum[WIDTH-1:1]};
                lo_d  = {adder_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d      = ST_IDLE;
                    done_count_d = done_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_mul_adder_ctrl.sv
// Self-checking bench for seq_mul_adder_ctrl with an exact or XOR-approximate adder model.
module tb_seq_mul_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;
    logic [15:0] done_count;
    logic [7:0]  adder_a;
    logic [7:0]  adder_b;
    logic        adder_cin;
    logic [7:0]  adder_sum;
    logic        adder_cout;
    logic        approx;
    logic [8:0]  add_full;

    int errors = 0;
    int checks = 0;
    int exp_done = 0;

    always #5 clk = ~clk;

    assign add_full = {1'b0, adder_a} + {1'b0, adder_b} + {8'd0, adder_cin};
    assign {adder_cout, adder_sum} = approx ? {1'b0, adder_a ^ adder_b} : add_full;

    seq_mul_adder_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .busy(busy), .done_count(done_count),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One shift-add iteration on the 16-bit {hi,lo} pair, using the adder the bench models.
    function automatic logic [15:0] model_step(input logic [15:0] p, input logic [7:0] a, input logic apx);
        logic [7:0] addend;
        logic [8:0] s;
        addend = p[0] ? a : 8'd0;
        s = apx ? {1'b0, p[15:8] ^ addend} : ({1'b0, p[15:8]} + {1'b0, addend});
        return 16'(({s, p[7:0]}) >> 1);
    endfunction

    function automatic logic [15:0] model_product(input logic [7:0] a, input logic [7:0] b, input logic apx);
        logic [15:0] p;
        if (!apx) return 16'(a) * 16'(b);
        p = {8'd0, b};
        for (int i = 0; i < 8; i++) p = model_step(p, a, 1'b1);
        return p;
    endfunction

    // Full operation: accept, count BUSY cycles, check result, hand off.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic chk_adder);
        logic [15:0] mp;
        int cyc;
        mp = {8'd0, b};
        check("op_in_ready", 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("op_busy", 32'(busy), 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            if (chk_adder) begin
                check("adder_a", 32'(adder_a), 32'(mp[15:8]));
                check("adder_b", 32'(adder_b), mp[0] ? 32'(a) : 32'd0);
            end
            mp = model_step(mp, a, approx);
            tick();
            cyc++;
        end
        check("busy_cycles", 32'(cyc), 32'd8);
        check("out_p", 32'(out_p), 32'(model_product(a, b, approx)));
        check("in_ready_done", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_done++;
        check("handoff_idle", 32'(in_ready), 32'd1);
        check("handoff_valid", 32'(out_valid), 32'd0);
        check("done_count", 32'(done_count), 32'(exp_done));
    endtask

    initial begin
        logic [15:0] held;
        logic [7:0]  qa[3];
        logic [7:0]  qb[3];
        int acc_cyc[3];
        int n_acc, n_out, cyc;
        logic acc_now, out_now;

        rst = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0; approx = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_p", 32'(out_p), 32'd0);
        check("rst_done_count", 32'(done_count), 32'd0);
        check("adder_cin", 32'(adder_cin), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        do_op(8'hFF, 8'hFF, 1'b1);
        check("ff_ff", 32'(out_p), 32'h0000FE01);
        do_op(8'h00, 8'hA5, 1'b1);
        do_op(8'h37, 8'h00, 1'b1);
        for (int i = 0; i < 1000; i++) do_op(8'($urandom), 8'($urandom), 1'b0);

        // Backpressure: result held while upstream keeps offering new operands.
        in_a = 8'h5A; in_b = 8'hC3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin tick(); cyc++; end
        check("bp_latency", 32'(cyc), 32'd8);
        held = out_p;
        check("bp_product", 32'(held), 32'(16'h5A * 16'hC3));
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_a = 8'($urandom);
            tick();
            check("bp_out_p", 32'(out_p), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        exp_done++;
        check("bp_release_idle", 32'(in_ready), 32'd1);
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_done_count", 32'(done_count), 32'(exp_done));
        in_valid = 1'b0; out_ready = 1'b0;
        tick();

        // Back-to-back with in_valid held and out_ready high.
        for (int i = 0; i < 3; i++) begin qa[i] = 8'($urandom); qb[i] = 8'($urandom); end
        n_acc = 0; n_out = 0; cyc = 0;
        in_a = qa[0]; in_b = qb[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (n_out < 3 && cyc < 200) begin
            acc_now = in_valid && in_ready;
            out_now = out_valid && out_ready;
            if (out_now) begin
                check("b2b_order", 32'(out_p), 32'(16'(qa[n_out]) * 16'(qb[n_out])));
                n_out++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 3) begin in_a = qa[n_acc]; in_b = qb[n_acc]; end
                else in_valid = 1'b0;
            end
        end
        exp_done += 3;
        check("b2b_outputs", 32'(n_out), 32'd3);
        check("b2b_accepts", 32'(n_acc), 32'd3);
        check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
        check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd10);
        check("b2b_done_count", 32'(done_count), 32'(exp_done));
        in_valid = 1'b0; out_ready = 1'b0;
        tick();

        // Approximate XOR adder stand-in.
        approx = 1'b1;
        do_op(8'h03, 8'h03, 1'b1);
        check("approx_3x3", 32'(out_p), 32'h00000005);
        for (int i = 0; i < 5; i++) do_op(8'($urandom), 8'($urandom), 1'b1);
        approx = 1'b0;

        // Asynchronous reset mid-operation, between clock edges.
        in_a = 8'hC8; in_b = 8'h9B; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_done = 0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_p", 32'(out_p), 32'd0);
        check("mid_rst_done_count", 32'(done_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid || busy) cyc++;
        end
        check("abandoned_op", 32'(cyc), 32'd0);
        do_op(8'd3, 8'd5, 1'b1);
        check("post_rst_3x5", 32'(out_p), 32'h0000000F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
